mem_initiator: RTL and testbench
================================

# mem_initiator

Core-side initiator for the 64-bit `ioMem_*` memory interface; it is the requesting end of the memory responder the simulation platform already provides. It accepts one load/store at a time from the LSU with byte/half/word/double sizing, and issues a doubleword-aligned `ioMem_ren` or `ioMem_wen`. For loads it waits for `ioMem_rvalid`, then lane-aligns and sign/zero-extends the data. It returns one response per request, with error reporting for misalignment, timeout and exhausted miss retries.

## Interface
- `TIMEOUT`, 16: max cycles waiting in RWAIT for `ioMem_rvalid` before error (≥2).
- `MAX_RETRY`, 3: read reissues allowed when `ioMem_hit`=0 at `ioMem_rvalid`.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `ioCore_valid`  in  1  request valid.
- `ioCore_ready`  out  1  request accepted when valid&&ready.
- `ioCore_wen`  in  1  1=store, 0=load.
- `ioCore_addr`  in  32  byte address.
- `ioCore_size`  in  2  0=B, 1=H, 2=W, 3=D.
- `ioCore_signed`  in  1  sign-extend load result.
- `ioCore_wData`  in  64  store data, right-justified.
- `ioCore_rvalid`  out  1  one-cycle response pulse.
- `ioCore_rData`  out  64  extended load data (0 for stores/errors).
- `ioCore_err`  out  1  valid with `ioCore_rvalid`.
- `ioMem_ren`  out  1  read request, one-cycle pulse.
- `ioMem_wen`  out  1  write request, one-cycle pulse.
- `ioMem_addr`  out  32  `{addr[31:3],3'b0}` while ren/wen high, else 0.
- `ioMem_wData`  out  64  lane-shifted store data.
- `ioMem_wMask`  out  8  byte enables.
- `ioMem_rData`  in  64  read data, valid with `ioMem_rvalid`.
- `ioMem_rvalid`  in  1  read data valid.
- `ioMem_hit`  in  1  qualifies `ioMem_rvalid`.

## Operation
- States: IDLE, RREQ, RWAIT, WREQ, RESP. `ioCore_ready`=1 only in IDLE.
- IDLE, accept:
  - Register addr/size/signed/wData/wen.
  - Misaligned (addr mod 2^size ≠ 0): go to RESP with err=1; no memory access.
  - Otherwise go to WREQ (store) or RREQ (load). Clear retry and timeout counters.
- RREQ: `ioMem_ren`=1 for exactly this cycle; next state RWAIT; timeout counter cleared.
- RWAIT:
  - `ioMem_rvalid`&&`ioMem_hit`: capture aligned data, go to RESP, err=0.
  - `ioMem_rvalid`&&!`ioMem_hit`: if retry<MAX_RETRY, increment retry and go to RREQ; else go to RESP with err=1.
  - No rvalid: increment counter. At count TIMEOUT-1, go to RESP with err=1.
- WREQ:
  - `ioMem_wen`=1 for this cycle with wMask = ((1<<(1<<size))-1) << addr[2:0], and wData = wData << (8·addr[2:0]).
  - Writes are accepted unconditionally and `ioMem_hit` is ignored. Next state RESP.
- RESP: `ioCore_rvalid`=1 for one cycle; then IDLE.
- Load extract:
  - Shift: r = `ioMem_rData` >> (8·addr[2:0]).
  - Truncate to 8/16/32/64 bits.
  - Extend: with signed=1, replicate the top bit of the truncated field; otherwise zero-fill.
- `ioMem_rvalid` outside RWAIT is ignored.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; all outputs 0 except `ioCore_ready`=1; counters 0.
- Reset mid-transaction aborts it with no response.
- Load (hit, responder with 1-cycle latency): accept at cycle 0, ren at cycle 1, rvalid at cycle 2, `ioCore_rvalid` at cycle 3.
- Store: accept at cycle 0, wen at cycle 1, `ioCore_rvalid` at cycle 2.
- Misaligned: accept at cycle 0, `ioCore_rvalid`+err at cycle 1.
- Timeout: err response TIMEOUT+1 cycles after ren.
- ren and wen are never high together, and each is never high in two consecutive cycles.

## Structure
- Shared package `mem_pkg`: size encoding constants (SZ_B/H/W/D), state enum, function mapping size to byte mask.
- Sub-module `mem_lane_align`: combinational store shift/mask generation and load shift/extend. The FSM and counters stay in `mem_initiator`.

## Test plan
- Load D, signed=0, addr 0x80000008, mem dword 0x1122334455667788:
  - ren pulse at cycle 1, ioMem_addr 0x80000008.
  - rData 0x1122334455667788, err=0, response at cycle 3.
- Load B:
  - signed=1, addr 0x80000003, same dword → rData 0xFFFFFFFFFFFFFF55? No: byte 3 = 0x55 → rData 0x0000000000000055.
  - addr 0x80000001 (byte 0x77, positive) → rData 0x77.
  - Byte 0x88 at addr 0x80000000 → rData 0xFFFFFFFFFFFFFF88.
- Store H at addr 0x80000006, wData 0xABCD → wMask 0xC0, ioMem_wData[63:48]=0xABCD, ioMem_addr 0x80000000, response at cycle 2, err=0.
- Misaligned W at addr 0x80000002 → no ren/wen ever, err=1 at cycle 1, rData 0.
- Responder holds hit=0 on every rvalid, MAX_RETRY=3 → exactly 4 ren pulses, then err=1. With rvalid never asserted, TIMEOUT=16 → err=1 17 cycles after ren.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the memory initiator and its lane-alignment helper.
// It holds the access-size encoding and the initiator state enum. It also holds
// the helpers that turn an access size into a byte-enable pattern or into a
// misalignment test.
// -----------------------------------------------------------------------------
package mem_pkg;

   // Access size encoding as presented by the LSU on ioCore_size
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RREQ,
      ST_RWAIT,
      ST_WREQ,
      ST_RESP
   } memState_t;

   // Byte enables for an access of the given size starting at lane 0
   function automatic logic [7:0] sizeToMask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         SZ_B:    mask = 8'h01;
         SZ_H:    mask = 8'h03;
         SZ_W:    mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // An access is misaligned when any address bit below its size is set
   function automatic logic isMisaligned(input logic [2:0] addrLow, input logic [1:0] size);
      logic [2:0] lowMask;
      case (size)
         SZ_B:    lowMask = 3'b000;
         SZ_H:    lowMask = 3'b001;
         SZ_W:    lowMask = 3'b011;
         default: lowMask = 3'b111;
      endcase
      return (addrLow & lowMask) != 3'b000;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for a 64-bit memory bus.
//   byteOffset_i  : addr[2:0] of the access
//   size_i        : access size (SZ_B..SZ_D)
//   isSigned_i    : sign-extend the load result
//   storeData_i   : right-justified store data
//   loadData_i    : raw doubleword returned by memory
//   laneWData_o   : store data shifted into its byte lanes
//   laneWMask_o   : byte enables for the store
//   extData_o     : load data moved down to bit 0 and extended to 64 bits
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  byteOffset_i,
   input  logic [1:0]  size_i,
   input  logic        isSigned_i,
   input  logic [63:0] storeData_i,
   input  logic [63:0] loadData_i,
   output logic [63:0] laneWData_o,
   output logic [7:0]  laneWMask_o,
   output logic [63:0] extData_o
);

   logic [5:0]  bitShift;
   logic [63:0] loadShifted;

   assign bitShift    = {byteOffset_i, 3'b000};
   assign laneWData_o = storeData_i << bitShift;
   assign laneWMask_o = sizeToMask(size_i) << byteOffset_i;
   assign loadShifted = loadData_i >> bitShift;

   // Keep only the addressed field of the shifted load data. The bits above it
   // are filled with the field's top bit for signed loads, or with 0 otherwise.
   always_comb begin
      extData_o = loadShifted;
      case (size_i)
         SZ_B:    extData_o = {{56{isSigned_i & loadShifted[7]}},  loadShifted[7:0]};
         SZ_H:    extData_o = {{48{isSigned_i & loadShifted[15]}}, loadShifted[15:0]};
         SZ_W:    extData_o = {{32{isSigned_i & loadShifted[31]}}, loadShifted[31:0]};
         default: extData_o = loadShifted;
      endcase
   end

endmodule

// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator
// Requesting end of the 64-bit ioMem interface. It takes one LSU load or store
// at a time and turns it into a doubleword-aligned read or write. It returns
// exactly one ioCore response per accepted request.
//   clock, reset        : rising-edge clock, async active-low reset
//   ioCore_valid/ready  : request handshake (ready only while idle)
//   ioCore_wen/addr/size/signed/wData : request fields
//   ioCore_rvalid/rData/err : one-cycle response with extended load data
//   ioMem_ren/wen       : one-cycle read/write request pulses
//   ioMem_addr/wData/wMask : aligned address, lane data, byte enables
//   ioMem_rData/rvalid/hit : read return path, hit qualifies rvalid
// -----------------------------------------------------------------------------
module mem_initiator
   import mem_pkg::*;
#(
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ioCore_valid,
   output logic        ioCore_ready,
   input  logic        ioCore_wen,
   input  logic [31:0] ioCore_addr,
   input  logic [1:0]  ioCore_size,
   input  logic        ioCore_signed,
   input  logic [63:0] ioCore_wData,
   output logic        ioCore_rvalid,
   output logic [63:0] ioCore_rData,
   output logic        ioCore_err,
   output logic        ioMem_ren,
   output logic        ioMem_wen,
   output logic [31:0] ioMem_addr,
   output logic [63:0] ioMem_wData,
   output logic [7:0]  ioMem_wMask,
   input  logic [63:0] ioMem_rData,
   input  logic        ioMem_rvalid,
   input  logic        ioMem_hit
);

   localparam int TO_W = $clog2(TIMEOUT);
   localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   memState_t   state_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [RT_W-1:0] retryCnt_q;
   logic [TO_W-1:0] timeoutCnt_q;

   logic        ready_q;
   logic        memRen_q;
   logic        memWen_q;
   logic [31:0] memAddr_q;
   logic [63:0] memWData_q;
   logic [7:0]  memWMask_q;
   logic        coreRValid_q;
   logic [63:0] coreRData_q;
   logic        coreErr_q;

   logic [2:0]  alignOffset;
   logic [1:0]  alignSize;
   logic [63:0] laneWData;
   logic [7:0]  laneWMask;
   logic [63:0] extData;

   // The store path runs on the request as it is being accepted. This lets the
   // write lanes be registered straight into the WREQ cycle. The load path
   // runs on the captured request.
   assign alignOffset = (state_q == ST_IDLE) ? ioCore_addr[2:0] : addr_q[2:0];
   assign alignSize   = (state_q == ST_IDLE) ? ioCore_size      : size_q;

   mem_lane_align uAlign (
      .byteOffset_i (alignOffset),
      .size_i       (alignSize),
      .isSigned_i   (signed_q),
      .storeData_i  (ioCore_wData),
      .loadData_i   (ioMem_rData),
      .laneWData_o  (laneWData),
      .laneWMask_o  (laneWMask),
      .extData_o    (extData)
   );

   // Single FSM with registered outputs. Every pulse output is cleared by
   // default each cycle. A pulse output is raised only on the transition into
   // the state that owns it, so it lasts exactly one cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         size_q       <= SZ_B;
         signed_q     <= 1'b0;
         retryCnt_q   <= '0;
         timeoutCnt_q <= '0;
         ready_q      <= 1'b1;
         memRen_q     <= 1'b0;
         memWen_q     <= 1'b0;
         memAddr_q    <= '0;
         memWData_q   <= '0;
         memWMask_q   <= '0;
         coreRValid_q <= 1'b0;
         coreRData_q  <= '0;
         coreErr_q    <= 1'b0;
      end else begin
         memRen_q     <= 1'b0;
         memWen_q     <= 1'b0;
         memAddr_q    <= '0;
         memWData_q   <= '0;
         memWMask_q   <= '0;
         coreRValid_q <= 1'b0;
         coreRData_q  <= '0;
         coreErr_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ioCore_valid) begin
                  addr_q       <= ioCore_addr;
                  size_q       <= ioCore_size;
                  signed_q     <= ioCore_signed;
                  retryCnt_q   <= '0;
                  timeoutCnt_q <= '0;
                  ready_q      <= 1'b0;
                  if (isMisaligned(ioCore_addr[2:0], ioCore_size)) begin
                     state_q      <= ST_RESP;
                     coreRValid_q <= 1'b1;
                     coreErr_q    <= 1'b1;
                  end else if (ioCore_wen) begin
                     state_q    <= ST_WREQ;
                     memWen_q   <= 1'b1;
                     memAddr_q  <= {ioCore_addr[31:3], 3'b000};
                     memWData_q <= laneWData;
                     memWMask_q <= laneWMask;
                  end else begin
                     state_q   <= ST_RREQ;
                     memRen_q  <= 1'b1;
                     memAddr_q <= {ioCore_addr[31:3], 3'b000};
                  end
               end
            end
            ST_RREQ: begin
               state_q      <= ST_RWAIT;
               timeoutCnt_q <= '0;
            end
            ST_RWAIT: begin
               // A hit completes the load. A miss either reissues the read or
               // gives up once the retries are used. Silence counts toward the
               // timeout.
               if (ioMem_rvalid && ioMem_hit) begin
                  state_q      <= ST_RESP;
                  coreRValid_q <= 1'b1;
                  coreRData_q  <= extData;
               end else if (ioMem_rvalid) begin
                  if (retryCnt_q < RT_W'(MAX_RETRY)) begin
                     retryCnt_q <= retryCnt_q + 1'b1;
                     state_q    <= ST_RREQ;
                     memRen_q   <= 1'b1;
                     memAddr_q  <= {addr_q[31:3], 3'b000};
                  end else begin
                     state_q      <= ST_RESP;
                     coreRValid_q <= 1'b1;
                     coreErr_q    <= 1'b1;
                  end
               end else if (timeoutCnt_q == TO_W'(TIMEOUT - 1)) begin
                  state_q      <= ST_RESP;
                  coreRValid_q <= 1'b1;
                  coreErr_q    <= 1'b1;
               end else begin
                  timeoutCnt_q <= timeoutCnt_q + 1'b1;
               end
            end
            ST_WREQ: begin
               state_q      <= ST_RESP;
               coreRValid_q <= 1'b1;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ioCore_ready  = ready_q;
   assign ioCore_rvalid = coreRValid_q;
   assign ioCore_rData  = coreRData_q;
   assign ioCore_err    = coreErr_q;
   assign ioMem_ren     = memRen_q;
   assign ioMem_wen     = memWen_q;
   assign ioMem_addr    = memAddr_q;
   assign ioMem_wData   = memWData_q;
   assign ioMem_wMask   = memWMask_q;

endmodule

// File: tb/tb_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_initiator
// Self-checking bench for mem_initiator. The bench has three parts: a table of
// directed vectors, randomized transactions checked against a byte-level
// reference model, and hand-written sequences. The sequences cover retry,
// timeout, reset mid-transaction and stray rvalid pulses.
// -----------------------------------------------------------------------------
module tb_mem_initiator;

   localparam int TIMEOUT   = 16;
   localparam int MAX_RETRY = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        ioCore_valid;
   logic        ioCore_ready;
   logic        ioCore_wen;
   logic [31:0] ioCore_addr;
   logic [1:0]  ioCore_size;
   logic        ioCore_signed;
   logic [63:0] ioCore_wData;
   logic        ioCore_rvalid;
   logic [63:0] ioCore_rData;
   logic        ioCore_err;
   logic        ioMem_ren;
   logic        ioMem_wen;
   logic [31:0] ioMem_addr;
   logic [63:0] ioMem_wData;
   logic [7:0]  ioMem_wMask;
   logic [63:0] ioMem_rData;
   logic        ioMem_rvalid;
   logic        ioMem_hit;

   always #5 clock = ~clock;

   mem_initiator #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
      .clock         (clock),
      .reset         (reset),
      .ioCore_valid  (ioCore_valid),
      .ioCore_ready  (ioCore_ready),
      .ioCore_wen    (ioCore_wen),
      .ioCore_addr   (ioCore_addr),
      .ioCore_size   (ioCore_size),
      .ioCore_signed (ioCore_signed),
      .ioCore_wData  (ioCore_wData),
      .ioCore_rvalid (ioCore_rvalid),
      .ioCore_rData  (ioCore_rData),
      .ioCore_err    (ioCore_err),
      .ioMem_ren     (ioMem_ren),
      .ioMem_wen     (ioMem_wen),
      .ioMem_addr    (ioMem_addr),
      .ioMem_wData   (ioMem_wData),
      .ioMem_wMask   (ioMem_wMask),
      .ioMem_rData   (ioMem_rData),
      .ioMem_rvalid  (ioMem_rvalid),
      .ioMem_hit     (ioMem_hit)
   );

   // Responder with one-cycle read latency. Mode 0 always hits, mode 1 always
   // misses, and mode 2 never answers. A stray rvalid can be injected while
   // idle.
   int          respMode;
   logic [63:0] memDword;
   logic        strayRValid;
   logic        rValidQ;
   logic        hitQ;
   logic [63:0] rDataQ;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         rValidQ <= 1'b0;
         hitQ    <= 1'b0;
         rDataQ  <= '0;
      end else if (ioMem_ren && respMode != 2) begin
         rValidQ <= 1'b1;
         hitQ    <= (respMode == 0);
         rDataQ  <= memDword;
      end else begin
         rValidQ <= 1'b0;
         hitQ    <= 1'b0;
      end
   end

   assign ioMem_rvalid = rValidQ | strayRValid;
   assign ioMem_hit    = hitQ | strayRValid;
   assign ioMem_rData  = rDataQ;

   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model working on individual bytes rather than shifts
   function automatic logic [63:0] modelLoad(input logic [63:0] dw, input int off, input int size, input logic sgn);
      logic [63:0] r;
      int n;
      n = 1 << size;
      r = '0;
      for (int i = 0; i < n; i++) r[8*i +: 8] = dw[8*(off+i) +: 8];
      if (sgn && n < 8 && r[8*n-1]) r = r | (~64'd0 << (8*n));
      return r;
   endfunction

   function automatic logic [7:0] modelMask(input int off, input int size);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < (1 << size); i++) m[off+i] = 1'b1;
      return m;
   endfunction

   // Results observed during one transaction
   int          tRenCount, tWenCount, tFirstRen, tRespCycle, tViol;
   logic [31:0] tRenAddr, tWenAddr;
   logic [7:0]  tMask;
   logic [63:0] tWData, tRData;
   logic        tErr;

   // Offer one request at a negedge and follow it cycle by cycle. The request
   // is accepted in cycle 0. Each later negedge is sampled as cycle 1, 2, ...
   // Protocol rules are tallied as they are watched.
   task automatic applyStimulus(input logic isStore, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [63:0] wData, input int limit);
      logic prevRen, prevWen;
      tRenCount = 0; tWenCount = 0; tFirstRen = -1; tRespCycle = -1; tViol = 0;
      tRenAddr = '0; tWenAddr = '0; tMask = '0; tWData = '0; tRData = '0; tErr = 1'b0;
      prevRen = 1'b0; prevWen = 1'b0;
      @(negedge clock);
      if (ioCore_ready !== 1'b1) tViol++;
      ioCore_valid = 1'b1; ioCore_wen = isStore; ioCore_addr = addr;
      ioCore_size = size; ioCore_signed = sgn; ioCore_wData = wData;
      for (int cyc = 1; cyc <= limit && tRespCycle < 0; cyc++) begin
         @(negedge clock);
         ioCore_valid = 1'b0;
         if (ioMem_ren && ioMem_wen) tViol++;
         if ((ioMem_ren && prevRen) || (ioMem_wen && prevWen)) tViol++;
         if (!ioMem_ren && !ioMem_wen && ioMem_addr != 32'd0) tViol++;
         if (!ioCore_rvalid && (ioCore_err || ioCore_rData != 64'd0)) tViol++;
         if (ioCore_ready) tViol++;
         if (ioMem_ren) begin
            if (tRenCount == 0) begin tFirstRen = cyc; tRenAddr = ioMem_addr; end
            tRenCount++;
         end
         if (ioMem_wen) begin
            tWenCount++; tWenAddr = ioMem_addr; tMask = ioMem_wMask; tWData = ioMem_wData;
         end
         if (ioCore_rvalid) begin
            tRespCycle = cyc; tRData = ioCore_rData; tErr = ioCore_err;
         end
         prevRen = ioMem_ren; prevWen = ioMem_wen;
      end
      @(negedge clock);
      if (ioCore_rvalid || !ioCore_ready) tViol++;
   endtask

   typedef struct {
      logic        isStore;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [63:0] wData;
      logic [63:0] memData;
      int          expResp;
      logic        expErr;
      logic [63:0] expRData;
      int          expRen;
      int          expWen;
      logic [31:0] expMemAddr;
      logic [7:0]  expMask;
      logic [63:0] expWData;
   } vec_t;

   vec_t vecs[14];

   localparam logic [63:0] DW_A = 64'h1122334455667788;
   localparam logic [63:0] DW_B = 64'h80000000F0000000;

   initial begin
      vecs[0]  = '{1'b0, 32'h80000008, 2'd3, 1'b0, 64'd0, DW_A, 3, 1'b0, DW_A,                  1, 0, 32'h80000008, 8'h00, 64'd0};
      vecs[1]  = '{1'b0, 32'h80000003, 2'd0, 1'b1, 64'd0, DW_A, 3, 1'b0, 64'h55,                1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[2]  = '{1'b0, 32'h80000001, 2'd0, 1'b1, 64'd0, DW_A, 3, 1'b0, 64'h77,                1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[3]  = '{1'b0, 32'h80000000, 2'd0, 1'b1, 64'd0, DW_A, 3, 1'b0, 64'hFFFFFFFFFFFFFF88,  1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[4]  = '{1'b0, 32'h80000000, 2'd0, 1'b0, 64'd0, DW_A, 3, 1'b0, 64'h88,                1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[5]  = '{1'b0, 32'h80000006, 2'd1, 1'b1, 64'd0, DW_A, 3, 1'b0, 64'h1122,              1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[6]  = '{1'b0, 32'h80000004, 2'd2, 1'b1, 64'd0, DW_B, 3, 1'b0, 64'hFFFFFFFF80000000,  1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[7]  = '{1'b0, 32'h80000004, 2'd2, 1'b0, 64'd0, DW_B, 3, 1'b0, 64'h80000000,          1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[8]  = '{1'b0, 32'h80000002, 2'd1, 1'b1, 64'd0, DW_B, 3, 1'b0, 64'hFFFFFFFFFFFFF000,  1, 0, 32'h80000000, 8'h00, 64'd0};
      vecs[9]  = '{1'b1, 32'h80000006, 2'd1, 1'b0, 64'hABCD, DW_A, 2, 1'b0, 64'd0,              0, 1, 32'h80000000, 8'hC0, 64'hABCD000000000000};
      vecs[10] = '{1'b1, 32'h80000010, 2'd3, 1'b0, 64'h0123456789ABCDEF, DW_A, 2, 1'b0, 64'd0,  0, 1, 32'h80000010, 8'hFF, 64'h0123456789ABCDEF};
      vecs[11] = '{1'b0, 32'h80000002, 2'd2, 1'b0, 64'd0, DW_A, 1, 1'b1, 64'd0,                 0, 0, 32'h0, 8'h00, 64'd0};
      vecs[12] = '{1'b1, 32'h80000004, 2'd3, 1'b0, 64'hDEADBEEF, DW_A, 1, 1'b1, 64'd0,          0, 0, 32'h0, 8'h00, 64'd0};
      vecs[13] = '{1'b1, 32'h80000005, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFF5A, DW_A, 2, 1'b0, 64'd0,  0, 1, 32'h80000000, 8'h20, 64'hFFFF5A0000000000};
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          rtCount;
      logic [31:0] rnd;
      int          sz, off;
      logic        isSt, sg, mis;
      logic [63:0] wd;

      reset = 1'b0; ioCore_valid = 1'b0; ioCore_wen = 1'b0; ioCore_addr = '0;
      ioCore_size = '0; ioCore_signed = 1'b0; ioCore_wData = '0;
      respMode = 0; memDword = DW_A; strayRValid = 1'b0;

      // Reset state, sampled while reset is held and again after release
      repeat (3) @(negedge clock);
      checkOutput("reset ready", {63'd0, ioCore_ready}, 64'd1);
      checkOutput("reset outputs", {ioCore_rvalid, ioCore_err, ioMem_ren, ioMem_wen}, 64'd0);
      checkOutput("reset memAddr", {32'd0, ioMem_addr}, 64'd0);
      checkOutput("reset lanes", ioMem_wData | {56'd0, ioMem_wMask} | ioCore_rData, 64'd0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("post-reset ready", {63'd0, ioCore_ready}, 64'd1);

      // Directed table
      for (int v = 0; v < 14; v++) begin
         memDword = vecs[v].memData;
         applyStimulus(vecs[v].isStore, vecs[v].addr, vecs[v].size, vecs[v].sgn, vecs[v].wData, 30);
         checkOutput($sformatf("vec%0d respCycle", v), 64'(tRespCycle), 64'(vecs[v].expResp));
         checkOutput($sformatf("vec%0d err", v), {63'd0, tErr}, {63'd0, vecs[v].expErr});
         checkOutput($sformatf("vec%0d rData", v), tRData, vecs[v].expRData);
         checkOutput($sformatf("vec%0d renCount", v), 64'(tRenCount), 64'(vecs[v].expRen));
         checkOutput($sformatf("vec%0d wenCount", v), 64'(tWenCount), 64'(vecs[v].expWen));
         checkOutput($sformatf("vec%0d protocol", v), 64'(tViol), 64'd0);
         if (vecs[v].expRen > 0) begin
            checkOutput($sformatf("vec%0d renCycle", v), 64'(tFirstRen), 64'd1);
            checkOutput($sformatf("vec%0d renAddr", v), {32'd0, tRenAddr}, {32'd0, vecs[v].expMemAddr});
         end
         if (vecs[v].expWen > 0) begin
            checkOutput($sformatf("vec%0d wenAddr", v), {32'd0, tWenAddr}, {32'd0, vecs[v].expMemAddr});
            checkOutput($sformatf("vec%0d wMask", v), {56'd0, tMask}, {56'd0, vecs[v].expMask});
            checkOutput($sformatf("vec%0d wData", v), tWData, vecs[v].expWData);
         end
      end

      // Randomized transactions against the byte-level model
      for (int k = 0; k < 60; k++) begin
         sz  = $urandom_range(0, 3);
         off = $urandom_range(0, 7);
         if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
         mis = (off % (1 << sz)) != 0;
         isSt = 1'($urandom_range(0, 1));
         sg   = 1'($urandom_range(0, 1));
         wd   = {$urandom, $urandom};
         memDword = {$urandom, $urandom};
         rnd = $urandom;
         applyStimulus(isSt, {rnd[31:3], 3'(off)}, 2'(sz), sg, wd, 30);
         checkOutput($sformatf("rnd%0d protocol", k), 64'(tViol), 64'd0);
         if (mis) begin
            checkOutput($sformatf("rnd%0d misaligned resp", k), {64'(tRespCycle)}, 64'd1);
            checkOutput($sformatf("rnd%0d misaligned err/rData", k), {63'd0, tErr} | tRData, 64'd1);
            checkOutput($sformatf("rnd%0d misaligned access", k), 64'(tRenCount + tWenCount), 64'd0);
         end else if (isSt) begin
            checkOutput($sformatf("rnd%0d store resp", k), 64'(tRespCycle), 64'd2);
            checkOutput($sformatf("rnd%0d store err", k), {63'd0, tErr}, 64'd0);
            checkOutput($sformatf("rnd%0d store wen", k), 64'(tWenCount * 16 + tRenCount), 64'd16);
            checkOutput($sformatf("rnd%0d store addr", k), {32'd0, tWenAddr}, {32'd0, rnd[31:3], 3'b000});
            checkOutput($sformatf("rnd%0d store mask", k), {56'd0, tMask}, {56'd0, modelMask(off, sz)});
            checkOutput($sformatf("rnd%0d store data", k), tWData, wd << (8 * off));
         end else begin
            checkOutput($sformatf("rnd%0d load resp", k), 64'(tRespCycle), 64'd3);
            checkOutput($sformatf("rnd%0d load err", k), {63'd0, tErr}, 64'd0);
            checkOutput($sformatf("rnd%0d load ren", k), 64'(tRenCount * 16 + tWenCount), 64'd16);
            checkOutput($sformatf("rnd%0d load addr", k), {32'd0, tRenAddr}, {32'd0, rnd[31:3], 3'b000});
            checkOutput($sformatf("rnd%0d load data", k), tRData, modelLoad(memDword, off, sz, sg));
         end
      end

      // Every read misses: one issue plus MAX_RETRY reissues, two cycles each
      respMode = 1; memDword = DW_A;
      applyStimulus(1'b0, 32'h80000020, 2'd3, 1'b0, 64'd0, 60);
      checkOutput("retry renCount", 64'(tRenCount), 64'(MAX_RETRY + 1));
      checkOutput("retry err", {63'd0, tErr}, 64'd1);
      checkOutput("retry rData", tRData, 64'd0);
      checkOutput("retry respCycle", 64'(tRespCycle), 64'(2 * (MAX_RETRY + 1) + 1));
      checkOutput("retry protocol", 64'(tViol), 64'd0);

      // No rvalid at all: error TIMEOUT+1 cycles after the single ren
      respMode = 2;
      applyStimulus(1'b0, 32'h80000100, 2'd2, 1'b1, 64'd0, 60);
      checkOutput("timeout renCount", 64'(tRenCount), 64'd1);
      checkOutput("timeout delay", 64'(tRespCycle - tFirstRen), 64'(TIMEOUT + 1));
      checkOutput("timeout err", {63'd0, tErr}, 64'd1);
      checkOutput("timeout protocol", 64'(tViol), 64'd0);

      // Reset in the middle of a load that is waiting: no response may follow
      @(negedge clock);
      ioCore_valid = 1'b1; ioCore_wen = 1'b0; ioCore_addr = 32'h80000040; ioCore_size = 2'd3;
      @(negedge clock);
      ioCore_valid = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("midreset ready", {63'd0, ioCore_ready}, 64'd1);
      checkOutput("midreset pulses", {ioCore_rvalid, ioMem_ren, ioMem_wen}, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      rtCount = 0;
      repeat (TIMEOUT + 8) begin
         @(negedge clock);
         if (ioCore_rvalid || ioMem_ren || !ioCore_ready) rtCount++;
      end
      checkOutput("midreset silent", 64'(rtCount), 64'd0);

      // Stray rvalid while idle is ignored
      respMode = 0;
      rtCount = 0;
      @(negedge clock);
      strayRValid = 1'b1;
      repeat (2) begin
         @(negedge clock);
         if (ioCore_rvalid || ioMem_ren || !ioCore_ready) rtCount++;
      end
      strayRValid = 1'b0;
      @(negedge clock);
      if (ioCore_rvalid) rtCount++;
      checkOutput("stray rvalid ignored", 64'(rtCount), 64'd0);

      // Normal traffic still works afterwards
      memDword = DW_A;
      applyStimulus(1'b0, 32'h80000008, 2'd3, 1'b0, 64'd0, 30);
      checkOutput("recovery respCycle", 64'(tRespCycle), 64'd3);
      checkOutput("recovery rData", tRData, DW_A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
